spart_tx_arbiter: RTL and testbench
===================================

# spart_tx_arbiter

Round-robin arbiter and sequencer that shares the single transmit side of `spart_top` among several game-logic requesters (move sender, hit/miss reply, game-state sync, etc.). It latches the winning requester's 24-bit message, issues a one-cycle `send_tx` strobe with stable `tx_data`, and then blocks further sends for a programmed frame time. `spart_top` exposes no transmit-busy flag, so this hold-off prevents a new frame from clobbering one in flight. The block sits between the game FSMs and `spart_top`.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 1..8.
- `DATA_W`, 24: message width; must match `spart_top` `tx_data`.
- `FRAME_CYCLES`, 1000: clocks reserved per frame after `send_tx`; must be ≥1 and cover the full SPART frame including stop bits.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  level request per requester; bit i pairs with slice i of `req_data`.
- `req_data`  in  NUM_REQ*DATA_W  message i at bits [i*DATA_W +: DATA_W]; sampled only in the arbitration cycle.
- `grant`  out  NUM_REQ  one-hot one-cycle pulse; message i has been accepted.
- `done`  out  NUM_REQ  one-hot one-cycle pulse; frame hold-off for message i has elapsed.
- `send_tx`  out  1  one-cycle strobe to `spart_top.send_tx`.
- `tx_data`  out  DATA_W  to `spart_top.tx_data`; held stable from the `send_tx` cycle until the next grant.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, SEND, WAIT.
- IDLE: if any `req` bit is high, select the winner by round-robin and go to SEND. On that edge, load `tx_data` from the winner's slice, load the winner's index into `gnt_idx`, and set `last_ptr` to the winner. If no `req` bit is high, remain in IDLE.
- Round-robin order: search indices `last_ptr+1, last_ptr+2, …` modulo NUM_REQ, ending at `last_ptr` itself. The first asserted index wins. `last_ptr` resets to NUM_REQ-1, so index 0 has priority after reset.
- SEND (exactly one cycle): `send_tx`=1 and `grant[gnt_idx]`=1. On the following edge, load the counter with FRAME_CYCLES-1 and go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle where the count is 0, assert `done[gnt_idx]`=1; on the next edge go to IDLE.
- Counter width is $clog2(FRAME_CYCLES); when FRAME_CYCLES=1 the width is 1. The counter never wraps because it is reloaded only in SEND.
- Requester contract:
  - Hold `req` and `req_data` stable until `grant` is seen.
  - Drop `req` in the cycle after `grant`.
  - A `req` still high when the FSM returns to IDLE is treated as a new message.
  - A `req` dropped before `grant` is withdrawn without any side effect.
- `req` changes during SEND or WAIT are ignored; the arbiter samples only in IDLE.
- `grant`, `send_tx`, `done` and `busy` decode from registered state plus `gnt_idx`, so they are glitch-free relative to `clk`.
- With NUM_REQ=1, the arbiter degenerates to a single-requester sequencer; `last_ptr` is constant 0.

## Timing
- Reset values: state=IDLE, `tx_data`=0, `gnt_idx`=0, `last_ptr`=NUM_REQ-1, counter=0. All outputs are 0.
- Reset is asynchronous in both directions of effect. Assertion mid-SEND or mid-WAIT forces IDLE immediately; no `done` is issued for the aborted message and the counter clears. The paired `spart_top` shares the reset source.
- Latency:
  - `req` high in IDLE at cycle t: `grant` and `send_tx` at t+1.
  - WAIT occupies t+2 .. t+1+FRAME_CYCLES.
  - `done` at t+1+FRAME_CYCLES.
  - Earliest next `send_tx`: t+3+FRAME_CYCLES, i.e. a minimum period of FRAME_CYCLES+2.
- Simultaneous requests: only one grant per arbitration cycle. The losers wait; each is served within NUM_REQ arbitration rounds (no starvation).
- `grant` and `done` are never asserted in the same cycle.

## Test plan
- Reset, then NUM_REQ=4 and FRAME_CYCLES=8; raise `req[2]` with data 24'hBEEFDE at cycle 10:
  - `grant`=4'b0100 and `send_tx`=1 at cycle 11.
  - `tx_data`=24'hBEEFDE from cycle 11 onward.
  - `done`=4'b0100 at cycle 19; `busy` high for cycles 11–19.
- `req`=4'b1111 held continuously (each requester re-raises after `done`): grant order 0,1,2,3,0.
  - Successive `send_tx` pulses are exactly 10 cycles apart.
- `req[1]` pulsed high for one cycle while the FSM is in WAIT, then dropped before IDLE: no grant to 1.
  - `send_tx` count is unchanged.
- Assert `rst` in the 4th WAIT cycle of a frame for requester 3:
  - All outputs go to 0 immediately, with no `done[3]`.
  - After release, `req`=4'b1001 grants 0 first.
- FRAME_CYCLES=1 and NUM_REQ=1 with `req` held high: `send_tx` every 3 cycles.
  - `done` arrives 1 cycle after each `send_tx`.
- Loopback of two `spart_top` instances with this arbiter driving the TX side and 24'hBEEFDE sent: the receiving side raises `interrupt_board` with `rx_data`=24'hBEEFDE before `done` pulses.

Source files
------------

// File: rtl/spart_tx_arbiter.sv
// Round-robin arbiter that shares the single spart_top transmit side among game requesters,
// holding off each new frame for FRAME_CYCLES clocks because spart_top exposes no busy flag.
module spart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = 24,
   parameter int FRAME_CYCLES = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        done,
   output logic                      send_tx,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   state_t           state;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] last_ptr;
   logic [CNT_W-1:0] cnt;

   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] probe_idx;
   logic             win_found;

   // Search starts just after the last winner and wraps to end on it, so no requester starves.
   always_comb begin
      win_idx   = '0;
      probe_idx = '0;
      win_found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         probe_idx = IDX_W'((int'(last_ptr) + i) % NUM_REQ);
         if (!win_found && req[probe_idx]) begin
            win_found = 1'b1;
            win_idx   = probe_idx;
         end
      end
   end

   // done is raised one edge early so that it lines up with the cycle in which the count reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tx_data  <= '0;
         gnt_idx  <= '0;
         last_ptr <= LAST_RST;
         cnt      <= '0;
         grant    <= '0;
         done     <= '0;
         send_tx  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         grant   <= '0;
         done    <= '0;
         send_tx <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  state    <= SEND;
                  tx_data  <= req_data[int'(win_idx)*DATA_W +: DATA_W];
                  gnt_idx  <= win_idx;
                  last_ptr <= win_idx;
                  grant    <= NUM_REQ'(1) << win_idx;
                  send_tx  <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            SEND: begin
               state <= WAIT;
               cnt   <= CNT_LOAD;
               if (FRAME_CYCLES == 1) done <= NUM_REQ'(1) << gnt_idx;
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_W'(1)) done <= NUM_REQ'(1) << gnt_idx;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spart_tx_arbiter.sv
// Directed bench: a 4-requester/8-cycle arbiter and a 1-requester/1-cycle arbiter side by side.
module tb_spart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [95:0] req_data = '0;
   logic [3:0]  grant, done;
   logic        send_tx, busy;
   logic [23:0] tx_data;

   logic [0:0]  req1 = '0;
   logic [23:0] req_data1 = '0;
   logic [0:0]  grant1, done1;
   logic        send_tx1, busy1;
   logic [23:0] tx_data1;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   spart_tx_arbiter #(.NUM_REQ(4), .DATA_W(24), .FRAME_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .grant(grant), .done(done), .send_tx(send_tx), .tx_data(tx_data), .busy(busy)
   );

   spart_tx_arbiter #(.NUM_REQ(1), .DATA_W(24), .FRAME_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .req(req1), .req_data(req_data1),
      .grant(grant1), .done(done1), .send_tx(send_tx1), .tx_data(tx_data1), .busy(busy1)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (busy && n < 30) begin
         step();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drain: busy=%b required 0", busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      checks++;
      if ({grant, done, send_tx, busy, tx_data} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h required 0", {grant, done, send_tx, busy, tx_data});
      end
      checks++;
      if ({grant1, done1, send_tx1, busy1, tx_data1} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs_n1: got %h required 0", {grant1, done1, send_tx1, busy1, tx_data1});
      end
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_single();
      req = 4'b0100;
      req_data[2*24 +: 24] = 24'hBEEFDE;
      step();
      checks++;
      if (grant !== 4'b0100 || send_tx !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_grant: grant=%b send_tx=%b required 0100/1", grant, send_tx);
      end
      checks++;
      if (tx_data !== 24'hBEEFDE) begin
         errors++;
         $display("[TB] FAIL single_data: got %h required beefde", tx_data);
      end
      req = 4'b0000;
      req_data = '0;
      for (int i = 1; i <= 7; i++) begin
         step();
         checks++;
         if (done !== 4'b0000 || busy !== 1'b1 || send_tx !== 1'b0 || tx_data !== 24'hBEEFDE) begin
            errors++;
            $display("[TB] FAIL single_wait%0d: done=%b busy=%b send=%b data=%h required 0000/1/0/beefde",
                     i, done, busy, send_tx, tx_data);
         end
      end
      step();
      checks++;
      if (done !== 4'b0100 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_done: done=%b busy=%b required 0100/1", done, busy);
      end
      step();
      checks++;
      if (done !== 4'b0000 || busy !== 1'b0 || tx_data !== 24'hBEEFDE) begin
         errors++;
         $display("[TB] FAIL single_idle: done=%b busy=%b data=%h required 0000/0/beefde", done, busy, tx_data);
      end
   endtask

   task automatic test_round_robin();
      int prev = 0;
      int overlap = 0;
      do_reset();
      for (int i = 0; i < 4; i++) req_data[i*24 +: 24] = 24'hA00000 + 24'(i);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         int n = 0;
         int exp_idx = k % 4;
         step();
         while (!send_tx && n < 20) begin
            if ((grant & done) != 4'b0000) overlap++;
            step();
            n++;
         end
         checks++;
         if (grant !== (4'b0001 << exp_idx) || tx_data !== 24'hA00000 + 24'(exp_idx)) begin
            errors++;
            $display("[TB] FAIL rr_grant%0d: grant=%b data=%h required %b/%h", k, grant, tx_data,
                     4'b0001 << exp_idx, 24'hA00000 + 24'(exp_idx));
         end
         if (k > 0) begin
            checks++;
            if (cyc - prev !== 10) begin
               errors++;
               $display("[TB] FAIL rr_period%0d: got %0d required 10", k, cyc - prev);
            end
         end
         prev = cyc;
      end
      req = 4'b0000;
      drain();
      checks++;
      if (overlap !== 0) begin
         errors++;
         $display("[TB] FAIL rr_grant_done_overlap: got %0d required 0", overlap);
      end
   endtask

   task automatic test_ignore_wait();
      int n = 0;
      int sends = 0;
      int g1 = 0;
      req = 4'b1000;
      req_data[3*24 +: 24] = 24'h333333;
      step();
      while (!send_tx && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (grant !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL ignore_first_grant: got %b required 1000", grant);
      end
      req = 4'b0000;
      step();
      step();
      req = 4'b0010;
      step();
      req = 4'b0000;
      for (int i = 0; i < 15; i++) begin
         if (send_tx) sends++;
         if (grant[1]) g1++;
         step();
      end
      checks++;
      if (sends !== 0 || g1 !== 0) begin
         errors++;
         $display("[TB] FAIL ignore_wait_pulse: sends=%0d grant1=%0d required 0/0", sends, g1);
      end
   endtask

   task automatic test_reset_abort();
      int n = 0;
      int done3 = 0;
      req = 4'b1000;
      req_data[3*24 +: 24] = 24'h777777;
      step();
      while (!send_tx && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (grant !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL abort_grant: got %b required 1000", grant);
      end
      req = 4'b0000;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (busy !== 1'b1 || done !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL abort_in_wait: busy=%b done=%b required 1/0000", busy, done);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({grant, done, send_tx, busy, tx_data} !== '0) begin
         errors++;
         $display("[TB] FAIL abort_async: got %h required 0", {grant, done, send_tx, busy, tx_data});
      end
      for (int i = 0; i < 3; i++) begin
         if (done[3]) done3++;
         step();
      end
      rst = 1'b0;
      req = 4'b1001;
      req_data[0 +: 24] = 24'h000111;
      step();
      checks++;
      if (grant !== 4'b0001 || tx_data !== 24'h000111) begin
         errors++;
         $display("[TB] FAIL abort_regrant: grant=%b data=%h required 0001/000111", grant, tx_data);
      end
      req = 4'b0000;
      for (int i = 0; i < 12; i++) begin
         if (done[3]) done3++;
         step();
      end
      checks++;
      if (done3 !== 0) begin
         errors++;
         $display("[TB] FAIL abort_no_done3: got %0d required 0", done3);
      end
      drain();
   endtask

   task automatic test_single_req();
      int n = 0;
      req1 = 1'b1;
      req_data1 = 24'h5A5A5A;
      step();
      while (!send_tx1 && n < 10) begin
         step();
         n++;
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (send_tx1 !== 1'b1 || grant1 !== 1'b1 || tx_data1 !== 24'h5A5A5A) begin
            errors++;
            $display("[TB] FAIL n1_send%0d: send=%b grant=%b data=%h required 1/1/5a5a5a",
                     k, send_tx1, grant1, tx_data1);
         end
         step();
         checks++;
         if (done1 !== 1'b1 || send_tx1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL n1_done%0d: done=%b send=%b busy=%b required 1/0/1", k, done1, send_tx1, busy1);
         end
         step();
         checks++;
         if (done1 !== 1'b0 || send_tx1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL n1_idle%0d: done=%b send=%b busy=%b required 0/0/0", k, done1, send_tx1, busy1);
         end
         step();
      end
      req1 = 1'b0;
   endtask

   initial begin
      test_reset();
      for (int i = 0; i < 8; i++) step();
      test_single();
      test_round_robin();
      test_ignore_wait();
      test_reset_abort();
      test_single_req();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
